viexo_console_writer: RTL

Character-stream front end for the text raster. Accepts an 8-bit ASCII byte stream on a valid/ready handshake in the aclk domain. Maintains a cursor and interprets control codes. Emits single-cell write commands (wen, wput_x, wput_y, wput_c) that feed the font renderer's character-write port.

---
 rtl/viexo_console_pkg.sv | 25 ++
 rtl/viexo_console_cursor.sv | 54 +++++
 rtl/viexo_console_writer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/viexo_console_pkg.sv
// Shared types and constants for the viexo console writer.
// HT decoding is present only when VIEXO_CONSOLE_TAB_EN is defined.
package viexo_console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    CLR_ROW,
    CLR_ALL,
    TAB
  } state_e;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] FF  = 8'h0C;
  localparam logic [7:0] HT  = 8'h09;
  localparam logic [7:0] DEL = 8'h7F;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } cell_t;

endpackage

// File: rtl/viexo_console_cursor.sv
// Text cursor register: advance with row wrap, back, CR, home and LF.
// o_row_req pulses for one cycle after any line advance.
module viexo_console_cursor
  import viexo_console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_adv,
  input  logic  i_lf,
  input  logic  i_back,
  input  logic  i_cr,
  input  logic  i_home,
  output cell_t o_pos,
  output logic  o_row_req
);

  localparam logic [7:0] COLS_M1 = 8'(COLS - 1);
  localparam logic [7:0] ROWS_M1 = 8'(ROWS - 1);

  cell_t r_pos;
  logic  r_row_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos     <= '0;
      r_row_req <= 1'b0;
    end else begin
      r_row_req <= 1'b0;
      if (i_home) begin
        r_pos <= '0;
      end else if (i_cr) begin
        r_pos.x <= 8'd0;
      end else if (i_back) begin
        r_pos.x <= r_pos.x - 8'd1;
      end else if (i_adv || i_lf) begin
        if (i_adv && (r_pos.x < COLS_M1)) begin
          r_pos.x <= r_pos.x + 8'd1;
        end else begin
          // LF keeps the column; only a printable wrap returns it to 0
          if (i_adv) r_pos.x <= 8'd0;
          r_pos.y   <= (r_pos.y < ROWS_M1) ? r_pos.y + 8'd1 : 8'd0;
          r_row_req <= 1'b1;
        end
      end
    end
  end

  assign o_pos     = r_pos;
  assign o_row_req = r_row_req;

endmodule

// File: rtl/viexo_console_writer.sv
// ASCII stream front end: cursor tracking, control decode, cell write slots.
// Define VIEXO_CONSOLE_TAB_EN to enable HT (tab stops every 8 columns).
//   state   | meaning
//   IDLE    | ready for a byte
//   GAP     | wen=1 cycle of a single write, wen drops next
//   CLR_ROW | blanking the cursor row
//   CLR_ALL | blanking the whole raster
//   TAB     | blanking cells up to the next tab stop
module viexo_console_writer
  import viexo_console_pkg::*;
#(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic       wen,
  output logic [7:0] wput_x,
  output logic [7:0] wput_y,
  output logic [7:0] wput_c,
  output logic       busy
);

  localparam logic [7:0] COLS_M1 = 8'(COLS - 1);
  localparam logic [7:0] ROWS_M1 = 8'(ROWS - 1);

  state_e     r_state, w_state_nx;
  logic       r_wen, w_wen_nx;
  logic [7:0] r_x, r_y, r_c, w_x_nx, w_y_nx, w_c_nx;
  logic [7:0] r_cnt_x, r_cnt_y, w_cnt_x_nx, w_cnt_y_nx;
  logic       r_ph, w_ph_nx;
  logic       r_tready;
  logic       w_accept;
  logic       w_adv, w_lf, w_back, w_cr, w_home;
  cell_t      w_pos;
  logic       w_row_req;

  viexo_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk       (aclk),
    .rst_n     (aresetn),
    .i_adv     (w_adv),
    .i_lf      (w_lf),
    .i_back    (w_back),
    .i_cr      (w_cr),
    .i_home    (w_home),
    .o_pos     (w_pos),
    .o_row_req (w_row_req)
  );

  assign w_accept = s_tvalid & r_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_wen    <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 8'd0;
      r_c      <= 8'd0;
      r_cnt_x  <= 8'd0;
      r_cnt_y  <= 8'd0;
      r_ph     <= 1'b0;
      r_tready <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_wen    <= w_wen_nx;
      r_x      <= w_x_nx;
      r_y      <= w_y_nx;
      r_c      <= w_c_nx;
      r_cnt_x  <= w_cnt_x_nx;
      r_cnt_y  <= w_cnt_y_nx;
      r_ph     <= w_ph_nx;
      r_tready <= (w_state_nx == IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wen_nx   = 1'b0;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_c_nx     = r_c;
    w_cnt_x_nx = r_cnt_x;
    w_cnt_y_nx = r_cnt_y;
    w_ph_nx    = r_ph;
    w_adv      = 1'b0;
    w_lf       = 1'b0;
    w_back     = 1'b0;
    w_cr       = 1'b0;
    w_home     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_x_nx = 8'd0;
        w_cnt_y_nx = 8'd0;
        w_ph_nx    = 1'b0;
        if (w_accept) begin
          if ((s_tdata >= 8'h20) && (s_tdata != DEL)) begin
            w_wen_nx   = 1'b1;
            w_x_nx     = w_pos.x;
            w_y_nx     = w_pos.y;
            w_c_nx     = s_tdata;
            w_adv      = 1'b1;
            w_state_nx = GAP;
          end else begin
            case (s_tdata)
              CR: w_cr = 1'b1;
              LF: begin
                w_lf       = 1'b1;
                w_state_nx = CLR_ROW;
              end
              BS: begin
                if (w_pos.x != 8'd0) begin
                  w_back     = 1'b1;
                  w_wen_nx   = 1'b1;
                  w_x_nx     = w_pos.x - 8'd1;
                  w_y_nx     = w_pos.y;
                  w_c_nx     = BLANK;
                  w_state_nx = GAP;
                end
              end
              FF: begin
                w_home     = 1'b1;
                w_state_nx = CLR_ALL;
              end
`ifdef VIEXO_CONSOLE_TAB_EN
              HT: w_state_nx = TAB;
`endif
              default: ;
            endcase
          end
        end
      end
      GAP: w_state_nx = w_row_req ? CLR_ROW : IDLE;
      CLR_ROW: begin
        if (!r_ph) begin
          w_wen_nx = 1'b1;
          w_x_nx   = r_cnt_x;
          w_y_nx   = w_pos.y;
          w_c_nx   = BLANK;
          w_ph_nx  = 1'b1;
        end else begin
          w_ph_nx    = 1'b0;
          w_cnt_x_nx = r_cnt_x + 8'd1;
          if (r_cnt_x == COLS_M1) w_state_nx = IDLE;
        end
      end
      CLR_ALL: begin
        if (!r_ph) begin
          w_wen_nx = 1'b1;
          w_x_nx   = r_cnt_x;
          w_y_nx   = r_cnt_y;
          w_c_nx   = BLANK;
          w_ph_nx  = 1'b1;
        end else begin
          w_ph_nx = 1'b0;
          if (r_cnt_x == COLS_M1) begin
            w_cnt_x_nx = 8'd0;
            if (r_cnt_y == ROWS_M1) w_state_nx = IDLE;
            else w_cnt_y_nx = r_cnt_y + 8'd1;
          end else begin
            w_cnt_x_nx = r_cnt_x + 8'd1;
          end
        end
      end
`ifdef VIEXO_CONSOLE_TAB_EN
      TAB: begin
        if (!r_ph) begin
          w_wen_nx = 1'b1;
          w_x_nx   = w_pos.x;
          w_y_nx   = w_pos.y;
          w_c_nx   = BLANK;
          w_ph_nx  = 1'b1;
        end else begin
          // stepping past the last column wraps the cursor and clears the new row
          w_ph_nx = 1'b0;
          w_adv   = 1'b1;
          if (w_pos.x == COLS_M1) w_state_nx = CLR_ROW;
          else if (w_pos.x[2:0] == 3'd7) w_state_nx = IDLE;
        end
      end
`endif
      default: w_state_nx = IDLE;
    endcase
  end

  assign s_tready = r_tready;
  assign wen      = r_wen;
  assign wput_x   = r_x;
  assign wput_y   = r_y;
  assign wput_c   = r_c;
  assign busy     = (r_state != IDLE);

endmodule
